// File: rtl/bus_arbiter.sv
// Round-robin arbiter granting N masters one at a time onto a shared single-slave bus.
// Grant 1 cycle after request; slave backpressure via s_ready, aborted after TIMEOUT_CYC cycles.
module bus_arbiter #(
  parameter int N_MASTERS   = 4,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_MASTERS-1:0]        m_valid,
  input  logic [N_MASTERS-1:0]        m_write,
  input  logic [N_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [N_MASTERS*DATA_W-1:0] m_wdata,
  output logic [N_MASTERS-1:0]        m_ready,
  output logic [DATA_W-1:0]           m_rdata,
  output logic [N_MASTERS-1:0]        m_grant,
  output logic                        s_valid,
  output logic                        s_read,
  output logic                        s_write,
  output logic [ADDR_W-1:0]           s_addr,
  output logic [DATA_W-1:0]           s_wdata,
  input  logic                        s_ready,
  input  logic [DATA_W-1:0]           s_rdata,
  output logic                        timeout_err,
  output logic                        busy
);

  localparam int IW = $clog2(N_MASTERS);
  localparam int CW = $clog2(TIMEOUT_CYC);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] g_q, g_d;
  logic [IW-1:0] last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_q, tmo_d;
  logic [IW-1:0] rr_sel;
  logic          rr_found;
  logic          xfer;
  logic          hs;

  assign xfer        = (state_q == XFER);
  assign busy        = xfer;
  assign timeout_err = tmo_q;
  assign m_rdata     = s_rdata;
  assign hs          = s_valid & s_ready;

  // First requester strictly after the previous owner, wrapping around.
  always_comb begin
    rr_found = 1'b0;
    rr_sel   = '0;
    for (int i = 1; i <= N_MASTERS; i++) begin
      int idx;
      idx = (int'(last_q) + i) % N_MASTERS;
      if (!rr_found && m_valid[idx]) begin
        rr_found = 1'b1;
        rr_sel   = IW'(idx);
      end
    end
  end

  always_comb begin
    m_grant = '0;
    s_valid = 1'b0;
    s_read  = 1'b0;
    s_write = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    if (xfer) begin
      m_grant[g_q] = 1'b1;
      s_valid      = m_valid[g_q];
      s_write      = m_write[g_q] & m_valid[g_q];
      s_read       = ~m_write[g_q] & m_valid[g_q];
      s_addr       = m_addr[int'(g_q)*ADDR_W +: ADDR_W];
      s_wdata      = m_wdata[int'(g_q)*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    m_ready = '0;
    if (hs) begin
      m_ready[g_q] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rr_found) begin
          state_d = XFER;
          g_d     = rr_sel;
          cnt_d   = '0;
        end
      end
      XFER: begin
        // Handshake is checked first so it wins over a same-cycle timeout.
        if (hs) begin
          state_d = IDLE;
          last_d  = g_q;
        end else if (!m_valid[g_q]) begin
          state_d = IDLE;
        end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          state_d = IDLE;
          last_d  = g_q;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      g_q     <= '0;
      last_q  <= IW'(N_MASTERS - 1);
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter N_MASTERS, default 4, number of requesting masters (2..8).
REQ-002 SHALL have parameter ADDR_W, default 16, address width.
REQ-003 SHALL have parameter DATA_W, default 32, data width.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 16, maximum XFER cycles without s_ready before abort (>=2).
REQ-005 SHALL use one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  clock; all state changes on posedge.
REQ-007 reset  in  1  asynchronous active-high reset.
REQ-008 m_valid  in  N_MASTERS  per-master request; held until m_ready.
REQ-009 m_write  in  N_MASTERS  per-master direction: 1 write, 0 read.
REQ-010 m_addr  in  N_MASTERS*ADDR_W  packed per-master address, master i at bits [i*ADDR_W +: ADDR_W].
REQ-011 m_wdata  in  N_MASTERS*DATA_W  packed per-master write data, same packing.
REQ-012 m_ready  out  N_MASTERS  per-master completion strobe.
REQ-013 m_rdata  out  DATA_W  read data broadcast to all masters.
REQ-014 m_grant  out  N_MASTERS  one-hot current owner; all zero when bus is free.
REQ-015 s_valid, s_read, s_write  out  1 each  shared-bus request and direction.
REQ-016 s_addr  out  ADDR_W; s_wdata  out  DATA_W  shared-bus address and write data.
REQ-017 s_ready  in  1; s_rdata  in  DATA_W  slave handshake and read data.
REQ-018 timeout_err  out  1  one-cycle pulse on timeout abort.
REQ-019 busy  out  1  high while state is XFER.

Function
REQ-020 SHALL implement FSM states IDLE and XFER, plus a registered owner index g and a round-robin pointer last.
REQ-021 In IDLE with any m_valid set, SHALL select the first set bit searching from (last+1) mod N_MASTERS upward with wrap-around, register g, and enter XFER at that edge.
REQ-022 Arbitration latency SHALL be 1 cycle: a request sampled at edge k gives m_grant[g]=1 and s_valid=1 in the cycle after edge k.
REQ-023 In XFER, s_valid SHALL equal m_valid[g]; s_write SHALL equal m_write[g] & s_valid; s_read SHALL equal ~m_write[g] & s_valid; s_addr and s_wdata SHALL mux combinationally from master g.
REQ-024 Outside XFER, s_valid, s_read, s_write SHALL be 0 and s_addr, s_wdata SHALL be 0.
REQ-025 m_ready[g] SHALL equal s_valid & s_ready combinationally; all other m_ready bits SHALL be 0.
REQ-026 m_rdata SHALL pass s_rdata through unchanged at all times.
REQ-027 On handshake (s_valid & s_ready), SHALL set last<=g and return to IDLE, giving one bus-free cycle between transactions.
REQ-028 A timeout counter SHALL clear on entry to XFER and increment on each XFER cycle without handshake.
REQ-029 When the counter reaches TIMEOUT_CYC-1 without handshake, SHALL abort: return to IDLE, set last<=g, and pulse timeout_err in the following cycle. No m_ready is issued.
REQ-030 If m_valid[g] deasserts during XFER, SHALL return to IDLE at the next edge without m_ready or timeout_err, and leave last unchanged.
REQ-031 If handshake and timeout occur in the same cycle, the handshake SHALL win and timeout_err SHALL stay 0.
REQ-032 Requests arriving during XFER SHALL be held off (no grant) until the next IDLE arbitration.
REQ-033 m_grant SHALL be one-hot0 at all times.

Reset
REQ-034 Asserting reset SHALL, asynchronously, force state IDLE, g=0, last=N_MASTERS-1 (master 0 highest priority next), counter 0, timeout_err 0.
REQ-035 During and after reset, until a new grant, all outputs except m_rdata SHALL be 0.
REQ-036 Reset mid-XFER SHALL drop the transaction with no m_ready.

Verification
REQ-037 Reset check: reset pulse with m_valid=4'b1111 -> m_grant=0, s_valid=0, busy=0 while reset is high; first grant after release goes to master 0.
REQ-038 Single write: master 2 writes addr 0x0010, data 0xDEADBEEF, s_ready high on 3rd XFER cycle -> m_grant=4'b0100, s_write=1, s_addr=0x0010, s_wdata=0xDEADBEEF, m_ready[2] pulses in that cycle, then busy=0.
REQ-039 Read: master 1 reads addr 0x0020, s_rdata=0x12345678, s_ready=1 -> m_ready[1]=1 with m_rdata=0x12345678 in the same cycle; s_read=1, s_write=0.
REQ-040 Fairness: m_valid=4'b1111 held, s_ready tied 1 -> grant order 0,1,2,3,0,... with one transaction per 2 cycles.
REQ-041 Timeout: master 3 requests, s_ready=0 -> abort after 16 XFER cycles, timeout_err pulses once, no m_ready; with masters 0 and 3 pending, the next grant goes to master 0.
REQ-042 Reset mid-XFER: assert reset in XFER cycle 2 -> m_grant and s_valid drop immediately (asynchronously), no m_ready.
